axi4_stream_mul_arbiter: RTL and testbench
==========================================

Name: axi4_stream_mul_arbiter

Overview:
Shares one AXI4-Stream multiplier slave between NREQ requesters (master wrappers). Grants one requester per transaction, round-robin at packet granularity. Forwards the granted request packet to the slave, then routes the slave's response packet back to the same requester before re-arbitrating. Sits between N master wrappers and a single slave wrapper in one clock domain.

Parameters:
NREQ, 2, number of requesters (2..8)
DSZ, 8, stream data width in bits
IDW, 3, width of grant_id (at least clog2(NREQ))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_tdata  in  NREQ*DSZ  request data, requester i in bits [i*DSZ +: DSZ]
req_tvalid  in  NREQ  request valid per requester
req_tlast  in  NREQ  request last per requester
req_tready  out  NREQ  request ready per requester
rsp_tdata  out  DSZ  response data, broadcast to all requesters
rsp_tlast  out  1  response last, broadcast
rsp_tvalid  out  NREQ  response valid per requester
rsp_tready  in  NREQ  response ready per requester
tdata_to_slave  out  DSZ  request data to slave
tvalid_to_slave  out  1  request valid to slave
tlast_to_slave  out  1  request last to slave
tready_to_slave  in  1  slave ready for request
tdata_to_master  in  DSZ  response data from slave
tvalid_to_master  in  1  response valid from slave
tlast_to_master  in  1  response last from slave
tready_to_master  out  1  arbiter ready for response
grant  out  NREQ  one-hot current grant, 0 in IDLE
grant_id  out  IDW  index of current or last grant
busy  out  1  state != IDLE
txn_count  out  16  completed transactions, wraps at 0xFFFF->0

Behaviour:
- FSM states: IDLE, REQ, RSP. Registers: state, grant_id, rr_ptr, txn_count.
- Reset (sync, rst=1 at edge): state=IDLE, rr_ptr=0, grant_id=0, txn_count=0. Applies mid-packet; the interrupted packet is abandoned. All valid/ready/grant outputs are 0 while state=IDLE.
- IDLE: all req_tready=0, tready_to_master=0, tvalid_to_slave=0. If any req_tvalid=1, pick the first i with req_tvalid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ. Next edge: grant_id=i, state=REQ. Arbitration latency is 1 cycle; no data transfers in IDLE.
- REQ: combinational pass-through, zero latency. tdata/tvalid/tlast_to_slave = req_*[grant_id]. req_tready[grant_id] = tready_to_slave; other req_tready=0. A handshake (tvalid_to_slave & tready_to_slave) with tlast_to_slave=1 -> RSP on the next edge. tready_to_master=0 in REQ, so an early slave response stalls.
- RSP: rsp_tdata=tdata_to_master and rsp_tlast=tlast_to_master. rsp_tvalid[grant_id]=tvalid_to_master; others 0. tready_to_master=rsp_tready[grant_id]. A handshake with tlast_to_master=1 -> IDLE, rr_ptr=(grant_id+1) mod NREQ, txn_count+1.
- rsp_tvalid is 0 outside RSP. req_tready is 0 outside REQ. Response data is never dropped or duplicated.
- Grant is held until request tlast and response tlast. Requests from other requesters wait with tready=0. A granted requester that drops tvalid mid-packet keeps the grant.
- No beat count limit. Packet boundaries are defined only by tlast. A single-beat packet (tlast on beat 1) is legal in both directions.
- grant = one-hot(grant_id) when busy, else 0. grant_id keeps its last value in IDLE.

Test Plan:
- Single requester: req0 sends 8 bytes (a=12551 then b=41245, LSB first, tlast on beat 8); the stub slave returns 8 bytes of 517665995 -> all 8 request beats reach the slave in order, the response appears only on rsp_tvalid[0], txn_count=1, back in IDLE.
- Simultaneous requests from req0 and req1 at rr_ptr=0 -> req0 is served fully (request and response), then req1. grant goes 01, 0, 10. rr_ptr ends at 0. txn_count=2.
- Fairness: req0 and req1 request continuously for 6 transactions -> grant order 0,1,0,1,0,1. Neither requester is starved.
- Backpressure: tready_to_slave toggles every cycle, and rsp_tready[0] is low for 5 cycles mid-response -> no beat is lost or duplicated. tready_to_master follows rsp_tready[0] exactly. The slave raises response valid during REQ -> it stalls until RSP.
- Reset mid-operation: rst=1 for 1 cycle after beat 3 of the req1 request -> next cycle busy=0, grant=0, txn_count=0, rr_ptr=0. A new req1 request is granted 1 cycle later.
- Wrap: txn_count is preloaded via 65535 transactions (or forced) -> the next completion reads 0. Single-beat request and response packets complete correctly.

Source files
------------

// File: rtl/axi4_stream_mul_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream multiplier slave
// among NREQ requesters. A grant covers one full request packet followed by
// the matching response packet; only then is the next requester chosen.
module axi4_stream_mul_arbiter #(
    parameter int NREQ = 2,
    parameter int DSZ  = 8,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*DSZ-1:0]  req_tdata,
    input  logic [NREQ-1:0]      req_tvalid,
    input  logic [NREQ-1:0]      req_tlast,
    output logic [NREQ-1:0]      req_tready,
    output logic [DSZ-1:0]       rsp_tdata,
    output logic                 rsp_tlast,
    output logic [NREQ-1:0]      rsp_tvalid,
    input  logic [NREQ-1:0]      rsp_tready,
    output logic [DSZ-1:0]       tdata_to_slave,
    output logic                 tvalid_to_slave,
    output logic                 tlast_to_slave,
    input  logic                 tready_to_slave,
    input  logic [DSZ-1:0]       tdata_to_master,
    input  logic                 tvalid_to_master,
    input  logic                 tlast_to_master,
    output logic                 tready_to_master,
    output logic [NREQ-1:0]      grant,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic [15:0]          txn_count
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;

    logic           found;
    logic [IDW-1:0] pick;
    int             j;

    logic [NREQ-1:0] gsel;
    logic [DSZ-1:0]  sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            sel_rrdy;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_tvalid[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    // Decode grant_id and mux the granted requester's signals.
    always_comb begin
        gsel      = '0;
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_rrdy  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            gsel[i] = (grant_id == IDW'(i));
            if (gsel[i]) begin
                sel_data  = sel_data | req_tdata[i*DSZ +: DSZ];
                sel_valid = req_tvalid[i];
                sel_last  = req_tlast[i];
                sel_rrdy  = rsp_tready[i];
            end
        end
    end

    // Zero-latency pass-through in both directions, gated by the phase.
    always_comb begin
        busy             = (state != IDLE);
        grant            = busy ? gsel : '0;
        tdata_to_slave   = sel_data;
        tvalid_to_slave  = (state == REQ) && sel_valid;
        tlast_to_slave   = (state == REQ) && sel_last;
        req_tready       = (state == REQ && tready_to_slave) ? gsel : '0;
        rsp_tdata        = tdata_to_master;
        rsp_tlast        = tlast_to_master;
        rsp_tvalid       = (state == RSP && tvalid_to_master) ? gsel : '0;
        tready_to_master = (state == RSP) && sel_rrdy;
    end

    // Phase sequencing; grant_id is only rewritten on a new arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant_id <= pick;
                    state    <= REQ;
                end
                REQ: if (tvalid_to_slave && tready_to_slave && tlast_to_slave)
                    state <= RSP;
                RSP: if (tvalid_to_master && tready_to_master && tlast_to_master) begin
                    state     <= IDLE;
                    rr_ptr    <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
                    txn_count <= txn_count + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_stream_mul_arbiter.sv
// Directed bench for axi4_stream_mul_arbiter: bench drives both requesters and
// a stub slave, logs every accepted beat and grant change, and compares the
// logs against hand-computed packets.
module tb_axi4_stream_mul_arbiter;

    localparam int NREQ = 2;
    localparam int DSZ  = 8;
    localparam int IDW  = 3;
    localparam int TMO  = 400;

    typedef logic [7:0] bq_t[$];

    logic                clk;
    logic                rst;
    logic [NREQ*DSZ-1:0] req_tdata;
    logic [NREQ-1:0]     req_tvalid;
    logic [NREQ-1:0]     req_tlast;
    logic [NREQ-1:0]     req_tready;
    logic [DSZ-1:0]      rsp_tdata;
    logic                rsp_tlast;
    logic [NREQ-1:0]     rsp_tvalid;
    logic [NREQ-1:0]     rsp_tready;
    logic [DSZ-1:0]      tdata_to_slave;
    logic                tvalid_to_slave;
    logic                tlast_to_slave;
    logic                tready_to_slave;
    logic [DSZ-1:0]      tdata_to_master;
    logic                tvalid_to_master;
    logic                tlast_to_master;
    logic                tready_to_master;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic                busy;
    logic [15:0]         txn_count;

    axi4_stream_mul_arbiter #(.NREQ(NREQ), .DSZ(DSZ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast),
        .req_tready(req_tready),
        .rsp_tdata(rsp_tdata), .rsp_tlast(rsp_tlast), .rsp_tvalid(rsp_tvalid),
        .rsp_tready(rsp_tready),
        .tdata_to_slave(tdata_to_slave), .tvalid_to_slave(tvalid_to_slave),
        .tlast_to_slave(tlast_to_slave), .tready_to_slave(tready_to_slave),
        .tdata_to_master(tdata_to_master), .tvalid_to_master(tvalid_to_master),
        .tlast_to_master(tlast_to_master), .tready_to_master(tready_to_master),
        .grant(grant), .grant_id(grant_id), .busy(busy), .txn_count(txn_count)
    );

    int  n_chk = 0;
    int  n_fail = 0;
    bq_t sq, rq0, rq1, gq;
    int  n_req_done = 0;
    int  n_grants = 0;
    int  sl_done = 0;
    bit  m_rsp = 0;
    bit  sl_early = 0;
    bit  sl_toggle = 0;
    bit  chk_bp = 0;
    bq_t sl_pkt;
    logic [NREQ-1:0] prev_g = '0;
    int  s_sq, s_r0, s_r1, s_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pack queue entries from index s onward, first entry in the low bits.
    function automatic logic [63:0] packq(input bq_t q, input int s, input int w);
        logic [63:0] r = '0;
        for (int i = s; i < q.size(); i++) r = r | (64'(q[i]) << (w * (i - s)));
        return r;
    endfunction

    task automatic mark();
        s_sq = sq.size(); s_r0 = rq0.size(); s_r1 = rq1.size(); s_g = gq.size();
    endtask

    // Requester driver; hole inserts a valid drop before beat 2, stop abandons the packet.
    task automatic send_pkt(input int id, input bq_t d, input bit hole, input int stop);
        int t;
        for (int b = 0; b < d.size(); b++) begin
            @(negedge clk);
            if (b == stop) begin
                req_tvalid[id] = 1'b0; req_tlast[id] = 1'b0;
                return;
            end
            if (hole && b == 2) begin
                req_tvalid[id] = 1'b0;
                repeat (3) @(negedge clk);
            end
            req_tvalid[id] = 1'b1;
            req_tdata[id*8 +: 8] = d[b];
            req_tlast[id] = (b == d.size() - 1);
            t = 0;
            #4;
            while (!req_tready[id] && t < TMO) begin @(negedge clk); #4; t++; end
            if (!req_tready[id]) chk($sformatf("req%0d_tmo", id), 64'(req_tready[id]), 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        req_tvalid[id] = 1'b0; req_tlast[id] = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        int t = 0;
        while ((sl_done < n || busy) && t < TMO) begin @(negedge clk); t++; end
        #1;
        if (t >= TMO) chk("idle_tmo", 64'(sl_done), 64'(n));
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
    endtask

    // Request-side ready: steady high, or toggling each cycle.
    initial begin
        tready_to_slave = 1'b1;
        forever begin
            @(negedge clk);
            tready_to_slave = sl_toggle ? ~tready_to_slave : 1'b1;
        end
    end

    // Stub slave: answers each request packet with sl_pkt; in early mode it
    // starts presenting the response as soon as a grant appears.
    initial begin
        int t;
        tvalid_to_master = 1'b0; tlast_to_master = 1'b0; tdata_to_master = '0;
        forever begin
            @(negedge clk);
            if (sl_early ? (n_grants > sl_done) : (n_req_done > sl_done)) begin
                for (int b = 0; b < sl_pkt.size(); b++) begin
                    if (b > 0) @(negedge clk);
                    tvalid_to_master = 1'b1;
                    tdata_to_master  = sl_pkt[b];
                    tlast_to_master  = (b == sl_pkt.size() - 1);
                    t = 0;
                    #4;
                    while (!tready_to_master && t < TMO) begin @(negedge clk); #4; t++; end
                    if (!tready_to_master) chk("slv_tmo", 64'(tready_to_master), 64'd1);
                    @(posedge clk);
                end
                @(negedge clk);
                tvalid_to_master = 1'b0; tlast_to_master = 1'b0;
                sl_done++;
            end
        end
    end

    // Beat and grant logger, sampled just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (chk_bp) begin
                chk("trm_follow", 64'(tready_to_master), 64'(m_rsp && rsp_tready[0]));
                chk("rsp_valid", 64'(rsp_tvalid), (m_rsp && tvalid_to_master) ? 64'd1 : 64'd0);
            end
            if (rst) m_rsp = 1'b0;
            else begin
                if (tvalid_to_slave && tready_to_slave) begin
                    sq.push_back(tdata_to_slave);
                    if (tlast_to_slave) begin n_req_done++; m_rsp = 1'b1; end
                end
                if (rsp_tvalid[0] && rsp_tready[0]) rq0.push_back(rsp_tdata);
                if (rsp_tvalid[1] && rsp_tready[1]) rq1.push_back(rsp_tdata);
                if (tvalid_to_master && tready_to_master && tlast_to_master) m_rsp = 1'b0;
            end
            if (grant != prev_g) begin
                gq.push_back(8'(grant));
                if (grant != '0) n_grants++;
                prev_g = grant;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t pa, pb;
        rst = 1'b1; req_tdata = '0; req_tvalid = '0; req_tlast = '0; rsp_tready = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_txn", 64'(txn_count), 64'd0);
        chk("rst_reqrdy", 64'(req_tready), 64'd0);
        chk("rst_tvs", 64'(tvalid_to_slave), 64'd0);
        chk("rst_trm", 64'(tready_to_master), 64'd0);
        chk("rst_rspv", 64'(rsp_tvalid), 64'd0);

        // Single requester: a=12551, b=41245 in, product 517665995 back
        mark();
        sl_pkt = {8'hCB, 8'hF4, 8'hDA, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00};
        pa = {8'h07, 8'h31, 8'h00, 8'h00, 8'h1D, 8'hA1, 8'h00, 8'h00};
        send_pkt(0, pa, 0, 99);
        wait_idle(1);
        chk("t1_req", packq(sq, s_sq, 8), 64'h0000A11D_00003107);
        chk("t1_req_n", 64'(sq.size() - s_sq), 64'd8);
        chk("t1_rsp0", packq(rq0, s_r0, 8), 64'h00000000_1EDAF4CB);
        chk("t1_rsp0_n", 64'(rq0.size() - s_r0), 64'd8);
        chk("t1_rsp1_n", 64'(rq1.size() - s_r1), 64'd0);
        chk("t1_txn", 64'(txn_count), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_grants", packq(gq, s_g, 4), 64'h01);

        // Simultaneous requests from rr_ptr=0
        pulse_rst();
        mark();
        sl_pkt = {8'hA5, 8'h5A};
        pa = {8'h11, 8'h12};
        pb = {8'h21};
        fork
            send_pkt(0, pa, 0, 99);
            send_pkt(1, pb, 0, 99);
        join
        wait_idle(3);
        chk("t2_req", packq(sq, s_sq, 8), 64'h211211);
        chk("t2_rsp0", packq(rq0, s_r0, 8), 64'h5AA5);
        chk("t2_rsp1", packq(rq1, s_r1, 8), 64'h5AA5);
        chk("t2_grants", packq(gq, s_g, 4), 64'h0201);
        chk("t2_txn", 64'(txn_count), 64'd2);
        chk("t2_gid", 64'(grant_id), 64'd1);

        // Fairness under continuous requests
        mark();
        pa = {8'h0A};
        pb = {8'h1B};
        fork
            repeat (3) send_pkt(0, pa, 0, 99);
            repeat (3) send_pkt(1, pb, 0, 99);
        join
        wait_idle(9);
        chk("t3_req", packq(sq, s_sq, 8), 64'h1B0A1B0A1B0A);
        chk("t3_grants", packq(gq, s_g, 4), 64'h020102010201);
        chk("t3_rsp0_n", 64'(rq0.size() - s_r0), 64'd6);
        chk("t3_rsp1_n", 64'(rq1.size() - s_r1), 64'd6);
        chk("t3_txn", 64'(txn_count), 64'd8);

        // Backpressure both ways, early slave response, valid hole mid-request
        mark();
        sl_pkt = {8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
        pa = {8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        sl_toggle = 1; sl_early = 1; chk_bp = 1;
        fork
            send_pkt(0, pa, 1, 99);
            begin
                int t = 0;
                while (rq0.size() < s_r0 + 3 && t < TMO) begin @(negedge clk); t++; end
                rsp_tready[0] = 1'b0;
                repeat (5) @(negedge clk);
                rsp_tready[0] = 1'b1;
            end
        join
        wait_idle(10);
        chk_bp = 0; sl_toggle = 0; sl_early = 0;
        chk("t4_req", packq(sq, s_sq, 8), 64'h454443424140);
        chk("t4_req_n", 64'(sq.size() - s_sq), 64'd6);
        chk("t4_rsp0", packq(rq0, s_r0, 8), 64'h87868584_83828180);
        chk("t4_rsp0_n", 64'(rq0.size() - s_r0), 64'd8);
        chk("t4_rsp1_n", 64'(rq1.size() - s_r1), 64'd0);
        chk("t4_txn", 64'(txn_count), 64'd9);

        // Reset after beat 3 of a req1 packet, then a fresh req1 packet
        mark();
        sl_pkt = {8'h99};
        pa = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(1, pa, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_grant", 64'(grant), 64'd0);
        chk("t5_txn", 64'(txn_count), 64'd0);
        chk("t5_part", packq(sq, s_sq, 8), 64'h030201);
        mark();
        pb = {8'h77};
        fork
            send_pkt(1, pb, 0, 99);
            begin
                @(negedge clk); #1;
                chk("t5_arb_busy", 64'(busy), 64'd0);
                chk("t5_arb_rdy", 64'(req_tready), 64'd0);
                @(negedge clk); #1;
                chk("t5_regrant", 64'(grant), 64'b10);
            end
        join
        wait_idle(11);
        chk("t5_req", packq(sq, s_sq, 8), 64'h77);
        chk("t5_rsp1", packq(rq1, s_r1, 8), 64'h99);
        chk("t5_txn2", 64'(txn_count), 64'd1);
        chk("t5_gid_hold", 64'(grant_id), 64'd1);

        // Counter wrap with single-beat packets both ways
        mark();
        @(negedge clk);
        force dut.txn_count = 16'hFFFF;
        @(negedge clk);
        release dut.txn_count;
        #1;
        chk("t6_pre", 64'(txn_count), 64'hFFFF);
        sl_pkt = {8'h3C};
        pa = {8'hC3};
        send_pkt(0, pa, 0, 99);
        wait_idle(12);
        chk("t6_wrap", 64'(txn_count), 64'd0);
        chk("t6_req", packq(sq, s_sq, 8), 64'hC3);
        chk("t6_rsp0", packq(rq0, s_r0, 8), 64'h3C);
        chk("t6_rsp0_n", 64'(rq0.size() - s_r0), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_grant", 64'(grant), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
